// File: rtl/eth_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the single 32-bit TX AXI-Stream port of mac_pcs.
// A grant is held for a whole frame; the output is registered through a 2-entry skid buffer.
module eth_tx_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [NUM_PORTS*32-1:0]        s_axis_tdata,
  input  logic [NUM_PORTS*4-1:0]         s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]           s_axis_tlast,
  output logic [NUM_PORTS-1:0]           s_axis_tready,
  output logic [31:0]                    m00_axis_tdata,
  output logic [3:0]                     m00_axis_tkeep,
  output logic                           m00_axis_tvalid,
  output logic                           m00_axis_tlast,
  input  logic                           m00_axis_tready,
  output logic [NUM_PORTS-1:0]           o_grant,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] o_frame_count
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_reg;
  logic [PW-1:0]        rr_ptr_reg;
  logic [PW-1:0]        gidx_reg;
  logic [NUM_PORTS-1:0] grant_reg;

  logic        out_valid_reg;
  logic        out_last_reg;
  logic [31:0] out_data_reg;
  logic [3:0]  out_keep_reg;
  logic        skid_full_reg;
  logic        skid_last_reg;
  logic [31:0] skid_data_reg;
  logic [3:0]  skid_keep_reg;

  logic [PW:0]   cand_sum [NUM_PORTS];
  logic [PW-1:0] cand_idx [NUM_PORTS];
  logic          pick_found;
  logic [PW-1:0] pick_idx;

  logic        in_valid;
  logic        in_last;
  logic [31:0] in_data;
  logic [3:0]  in_keep;
  logic        accept;
  logic        frame_done;

  // cand_idx[i] is the port i places after rr_ptr, wrapping modulo NUM_PORTS
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
    assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (PW+1)'(gi);
    assign cand_idx[gi] = (cand_sum[gi] >= (PW+1)'(NUM_PORTS)) ?
                          PW'(cand_sum[gi] - (PW+1)'(NUM_PORTS)) : PW'(cand_sum[gi]);
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_axis_tvalid[cand_idx[i]]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[i];
      end
    end
  end

  assign in_valid   = (state_reg == LOCKED) && s_axis_tvalid[gidx_reg];
  assign in_last    = s_axis_tlast[gidx_reg];
  assign in_data    = s_axis_tdata[gidx_reg*32 +: 32];
  assign in_keep    = s_axis_tkeep[gidx_reg*4 +: 4];
  assign accept     = in_valid && !skid_full_reg;
  assign frame_done = accept && in_last;

  // tready depends only on registered state, so m00_axis_tready never reaches a source
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
    assign s_axis_tready[gi] = grant_reg[gi] && !skid_full_reg;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      gidx_reg   <= '0;
      grant_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_reg <= NUM_PORTS'(1) << pick_idx;
            gidx_reg  <= pick_idx;
            state_reg <= LOCKED;
          end
        end
        LOCKED: begin
          if (frame_done) begin
            grant_reg  <= '0;
            state_reg  <= IDLE;
            rr_ptr_reg <= (gidx_reg == PW'(NUM_PORTS - 1)) ? '0 : gidx_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      skid_full_reg <= 1'b0;
      skid_last_reg <= 1'b0;
      skid_data_reg <= '0;
      skid_keep_reg <= '0;
    end else if (!out_valid_reg || m00_axis_tready) begin
      if (skid_full_reg) begin
        out_valid_reg <= 1'b1;
        out_last_reg  <= skid_last_reg;
        out_data_reg  <= skid_data_reg;
        out_keep_reg  <= skid_keep_reg;
        skid_full_reg <= 1'b0;
      end else if (accept) begin
        out_valid_reg <= 1'b1;
        out_last_reg  <= in_last;
        out_data_reg  <= in_data;
        out_keep_reg  <= in_keep;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      // output is held this cycle, so the beat parks behind it
      skid_full_reg <= 1'b1;
      skid_last_reg <= in_last;
      skid_data_reg <= in_data;
      skid_keep_reg <= in_keep;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_reg;
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        cnt_reg <= '0;
      end else if (frame_done && (gidx_reg == PW'(gi))) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
    assign o_frame_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
  end

  assign o_grant         = grant_reg;
  assign m00_axis_tvalid = out_valid_reg;
  assign m00_axis_tlast  = out_last_reg;
  assign m00_axis_tdata  = out_data_reg;
  assign m00_axis_tkeep  = out_keep_reg;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomized bench for eth_tx_arbiter: frame sources and a beat scoreboard drive a
// frame-level round-robin model that predicts grant, tready, output beats and counters.
module tb_eth_tx_arbiter;

  localparam int N  = 3;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            i_reset;
  logic [N*32-1:0] s_tdata;
  logic [N*4-1:0]  s_tkeep;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic [31:0]     m_tdata;
  logic [3:0]      m_tkeep;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;
  logic [N-1:0]    o_grant;
  logic [N*CW-1:0] o_frame_count;

  always #5 clk = ~clk;

  eth_tx_arbiter #(.NUM_PORTS(N), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m00_axis_tdata(m_tdata), .m00_axis_tkeep(m_tkeep), .m00_axis_tvalid(m_tvalid),
    .m00_axis_tlast(m_tlast), .m00_axis_tready(m_tready),
    .o_grant(o_grant), .o_frame_count(o_frame_count)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;

  int          src_frames[N];
  int          src_len[N];
  int          src_delay[N];
  int          gap_pct[N];
  int          beat_idx[N];
  int          cur_len[N];
  logic        keep_fix[N];
  logic        cur_valid[N];
  logic [31:0] cur_data[N];
  logic [3:0]  cur_keep[N];
  int          mready_pct;

  int   model_g;
  int   model_rr;
  int   model_cnt[N];
  logic rst_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    model_g  = -1;
    model_rr = 0;
    for (int p = 0; p < N; p++) begin
      model_cnt[p] = 0;
      cur_valid[p] = 1'b0;
      beat_idx[p]  = 0;
    end
  endtask

  task automatic config_port(input int p, input int frames, input int len, input int delay,
                             input int gap, input logic kfix);
    src_frames[p] = frames;
    src_len[p]    = len;
    src_delay[p]  = delay;
    gap_pct[p]    = gap;
    keep_fix[p]   = kfix;
  endtask

  task automatic drive(input logic rst);
    i_reset = rst;
    for (int p = 0; p < N; p++) begin
      if (src_delay[p] > 0) begin
        src_delay[p]--;
      end else if (!cur_valid[p] && src_frames[p] > 0 && $urandom_range(99) >= gap_pct[p]) begin
        if (beat_idx[p] == 0) cur_len[p] = (src_len[p] > 0) ? src_len[p] : int'($urandom_range(1, 8));
        cur_valid[p] = 1'b1;
        cur_data[p]  = $urandom;
        cur_keep[p]  = keep_fix[p] ? 4'b0001 : 4'($urandom);
      end
      s_tvalid[p]          = cur_valid[p];
      s_tdata[p*32 +: 32]  = cur_data[p];
      s_tkeep[p*4 +: 4]    = cur_keep[p];
      s_tlast[p]           = (beat_idx[p] == cur_len[p] - 1);
    end
    m_tready = ($urandom_range(99) < mready_pct);
  endtask

  task automatic sample();
    logic [N-1:0]    exp_gnt;
    logic [N-1:0]    exp_rdy;
    logic [N*CW-1:0] exp_cnt;
    int              fill;
    logic            found;
    beat_t           b;
    fill    = sb.size();
    exp_gnt = (model_g >= 0) ? (N'(1) << model_g) : '0;
    exp_rdy = (fill < 2) ? exp_gnt : '0;
    for (int p = 0; p < N; p++) exp_cnt[p*CW +: CW] = CW'(model_cnt[p]);
    chk("grant", 64'(o_grant), 64'(exp_gnt));
    chk("s_tready", 64'(s_tready), 64'(exp_rdy));
    chk("m_tvalid", 64'(m_tvalid), 64'(fill > 0));
    chk("frame_count", 64'(o_frame_count), 64'(exp_cnt));
    if (fill > 0) begin
      chk("m_tdata", 64'(m_tdata), 64'(sb[0].d));
      chk("m_tkeep", 64'(m_tkeep), 64'(sb[0].k));
      chk("m_tlast", 64'(m_tlast), 64'(sb[0].l));
    end
    if (rst_prev) begin
      chk("rst_tdata", 64'(m_tdata), 64'd0);
      chk("rst_tkeep", 64'(m_tkeep), 64'd0);
      chk("rst_tlast", 64'(m_tlast), 64'd0);
    end
    if (i_reset) begin
      model_reset();
    end else begin
      if (model_g < 0) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!found && s_tvalid[(model_rr + i) % N]) begin
            found   = 1'b1;
            model_g = (model_rr + i) % N;
          end
        end
      end else if (s_tvalid[model_g] && fill < 2 && s_tlast[model_g]) begin
        model_cnt[model_g] = (model_cnt[model_g] + 1) % (1 << CW);
        model_rr           = (model_g + 1) % N;
        model_g            = -1;
      end
      if (m_tvalid && m_tready && fill > 0) void'(sb.pop_front());
      for (int p = 0; p < N; p++) begin
        if (s_tvalid[p] && s_tready[p]) begin
          b.d = s_tdata[p*32 +: 32];
          b.k = s_tkeep[p*4 +: 4];
          b.l = s_tlast[p];
          sb.push_back(b);
          cur_valid[p] = 1'b0;
          if (s_tlast[p]) begin
            beat_idx[p] = 0;
            src_frames[p]--;
          end else begin
            beat_idx[p]++;
          end
        end
      end
    end
    rst_prev = i_reset;
  endtask

  task automatic cycle(input logic rst);
    @(posedge clk);
    #1;
    drive(rst);
    @(negedge clk);
    sample();
  endtask

  function automatic logic all_done();
    logic d;
    d = (sb.size() == 0) && (model_g < 0);
    for (int p = 0; p < N; p++) if (src_frames[p] > 0 || cur_valid[p]) d = 1'b0;
    return d;
  endfunction

  task automatic run_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      cycle(1'b0);
      n++;
    end
    chk({"timeout_", tag}, 64'(n < budget), 64'd1);
    $display("phase %s finished after %0d cycles, checks=%0d", tag, n, checks);
    cycle(1'b0);
    cycle(1'b0);
  endtask

  initial begin
    int n;
    i_reset    = 1'b1;
    s_tdata    = '0;
    s_tkeep    = '0;
    s_tvalid   = '0;
    s_tlast    = '0;
    m_tready   = 1'b1;
    mready_pct = 100;
    for (int p = 0; p < N; p++) begin
      config_port(p, 0, 1, 0, 0, 1'b0);
      cur_len[p]  = 1;
      cur_data[p] = '0;
      cur_keep[p] = '0;
    end
    model_reset();
    rst_prev = 1'b1;
    @(posedge clk);

    // reset held 3 cycles with requesters active, then 0/1 round-robin on 4-beat frames
    config_port(0, 2, 4, 0, 0, 1'b0);
    config_port(1, 2, 4, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1);
    cycle(1'b0);
    chk("first_grant_idle", 64'(o_grant), 64'd0);
    cycle(1'b0);
    chk("first_grant_port0", 64'(o_grant), 64'b001);
    run_done("round_robin", 200);
    chk("rr_count0", 64'(o_frame_count[0 +: CW]), 64'd2);
    chk("rr_count1", 64'(o_frame_count[CW +: CW]), 64'd2);

    // lock: port 1 requests during beat 2 of an 8-beat port-0 frame
    config_port(0, 1, 8, 0, 0, 1'b0);
    config_port(1, 1, 4, 3, 0, 1'b0);
    run_done("lock", 200);

    // backpressure on a 16-beat frame
    mready_pct = 50;
    config_port(0, 1, 16, 0, 0, 1'b0);
    run_done("backpressure", 400);

    // mixed random traffic with source gaps and output stalls
    mready_pct = 60;
    for (int p = 0; p < N; p++) config_port(p, 4, 0, 0, 30, 1'b0);
    run_done("random_mix", 2000);

    // single-beat frames from a lone requester
    mready_pct = 100;
    config_port(1, 8, 1, 0, 0, 1'b1);
    run_done("one_beat", 200);

    // counter wrap: 18 frames on a 4-bit counter from zero
    cycle(1'b1);
    config_port(2, 18, 1, 0, 0, 1'b0);
    run_done("wrap", 300);
    chk("wrap_count2", 64'(o_frame_count[2*CW +: CW]), 64'd2);

    // reset on beat 3 of a port-0 frame; the truncated frame is resent afterwards
    config_port(0, 1, 6, 0, 0, 1'b0);
    n = 0;
    while (beat_idx[0] < 3 && n < 50) begin
      cycle(1'b0);
      n++;
    end
    chk("timeout_midframe", 64'(n < 50), 64'd1);
    cycle(1'b1);
    cycle(1'b0);
    chk("midrst_grant", 64'(o_grant), 64'd0);
    chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_count0", 64'(o_frame_count[0 +: CW]), 64'd0);
    run_done("after_reset", 200);
    chk("resent_count0", 64'(o_frame_count[0 +: CW]), 64'd1);

    // long random run, all ports
    mready_pct = 70;
    for (int p = 0; p < N; p++) config_port(p, 6, 0, 0, 20, 1'b0);
    run_done("random_final", 3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
